sda_gmem_read_arbiter: RTL and testbench
========================================

Name: sda_gmem_read_arbiter

Overview:
- Shares the single gmem AXI4 master read channel (AR/R) between two internal read requesters, e.g. two action-side streaming readers.
- Arbitrates AR requests round-robin and issues them through a registered stage.
- Records the grant order in a route FIFO and steers R beats back to the owning requester. Beats are routed in order; no ID remapping is done.
- Sits between the action logic and the gmem master port inside the kernel wrapper. The wrapper still ties off cache/prot/qos/region/lock/id/user.

Parameters:
- ADDR_WIDTH, 64, AR address width.
- DATA_WIDTH, 32, R data width.
- MAX_OUTSTANDING, 4, maximum accepted-but-not-completed bursts. Power of two, range 2..16.
- OUTSTANDING_LOG2, 2, log2(MAX_OUTSTANDING).

Ports:
- clk  in  1  kernel clock
- reset  in  1  synchronous active-high reset
- s0_araddr / s1_araddr  in  ADDR_WIDTH  requester burst address
- s0_arlen / s1_arlen  in  8  beats-1
- s0_arsize / s1_arsize  in  3  beat size
- s0_arburst / s1_arburst  in  2  burst type
- s0_arvalid / s1_arvalid  in  1  request valid
- s0_arready / s1_arready  out  1  request accepted
- s0_rdata / s1_rdata  out  DATA_WIDTH  routed read data
- s0_rresp / s1_rresp  out  2  routed response
- s0_rlast / s1_rlast  out  1  routed last
- s0_rvalid / s1_rvalid  out  1  routed valid
- s0_rready / s1_rready  in  1  requester ready
- m_araddr, m_arlen, m_arsize, m_arburst  out  ADDR_WIDTH/8/3/2  to gmem AR
- m_arvalid  out  1
- m_arready  in  1
- m_rdata, m_rresp, m_rlast, m_rvalid  in  DATA_WIDTH/2/1/1  from gmem R
- m_rready  out  1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values: m_arvalid=0, s0/s1_arready=0, m_ar* data regs=0, route FIFO count=0, read/write pointers=0, last_grant=1 (so port 0 wins first), FSM=IDLE.
- AR FSM has two states, IDLE and ISSUE.
- IDLE:
  - If count<MAX_OUTSTANDING and any sN_arvalid, choose the winner. If both are valid, the winner is the port != last_grant; otherwise it is the single valid port.
  - In the same cycle, assert the winner's arready combinationally for exactly that cycle. The loser's arready stays 0.
  - On the next edge: latch the winner's addr/len/size/burst into the m_ar regs, set m_arvalid=1, push the winner index into the route FIFO, set last_grant=winner, go to ISSUE.
- ISSUE:
  - m_ar* stays stable while m_arvalid=1 and m_arready=0. Both arready outputs stay 0.
  - On m_arready=1: m_arvalid=0 at the next edge, return to IDLE.
- Throughput: 1 AR per 2 cycles minimum. Latency from sN handshake to m_arvalid is 1 cycle.
- Full: count==MAX_OUTSTANDING blocks all grants. arready stays 0 and requests wait; this is not an error.
- R routing (combinational, zero latency):
  - head = route FIFO head entry. Let sel be the port named by head, and other the remaining port.
  - sel_rvalid = m_rvalid & ~empty. other_rvalid = 0.
  - m_rready = ~empty & sel_rready.
  - rdata/rresp/rlast are fanned to both ports unconditionally. Only rvalid qualifies them.
- Pop: on m_rvalid & m_rready & m_rlast.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- Empty FIFO with m_rvalid=1 (slave protocol violation): m_rready=0, channel stalls, no beat is routed.
- Non-OKAY rresp: forwarded unchanged. The burst still completes on rlast.
- Reset mid-operation: all state returns to reset values next edge and outstanding bursts are forgotten. The whole action domain is reset together by the reset handler, so no drain is attempted.

Decomposition:
- Shared include sda_gmem_defs.vh holds:
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10;
  - default ADDR/DATA width defines, matching the wrapper's AXI_MASTER_* defaults.
- Sub-module sda_gmem_route_fifo: synchronous 1-bit-wide FIFO.
  - Parameters: depth/log2.
  - Ports: push, push_data, pop, head, empty, full, count; reset as above.
- Top: FSM, round-robin logic, R steering.

Test Plan:
1. s0 only, araddr=0x1000, arlen=3, size=2, burst=INCR:
   - s0_arready high 1 cycle;
   - m_arvalid next cycle with identical fields;
   - 4 R beats 0xA0..0xA3 appear on s0 with s0_rlast on the 4th;
   - s1_rvalid never asserts.
2. Both arvalid from reset, s0 addr 0x2000, s1 addr 0x3000, m_arready=1:
   - s0 is issued first, then s1 two cycles later;
   - R bursts (len 1 each) return in order to s0 then s1.
3. Both requesting continuously for 8 grants:
   - grant sequence 0,1,0,1,0,1,0,1;
   - never two consecutive grants to the same port.
4. MAX_OUTSTANDING=4, m_rvalid held 0, s0 requests continuously:
   - exactly 4 ARs issued, then s0_arready stays 0;
   - after one burst completes with rlast, a 5th AR issues.
5. m_arready held 0 for 10 cycles after issue:
   - m_araddr/len stable for all 10 cycles;
   - no arready on s0 or s1 meanwhile;
   - release leads to IDLE and the next grant.
6. reset asserted during the 2nd beat of a len=3 burst:
   - next cycle m_arvalid=0, m_rready=0, both s_rvalid=0, count=0;
   - the first post-reset request is granted to s0.

Source files
------------

// File: rtl/sda_gmem_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------------------------
// sda_gmem_read_arbiter_pkg
//   Shared definitions for the gmem read arbiter: AXI burst/response encodings, the default
//   AXI master address/data widths used by the kernel wrapper, the AR FSM state type and the
//   round-robin pick helper.
// ---------------------------------------------------------------------------------------------
package sda_gmem_read_arbiter_pkg;

  // AXI encodings used by the action side
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Default widths, matching the wrapper's gmem master port
  localparam int unsigned AXI_MASTER_ADDR_WIDTH = 64;
  localparam int unsigned AXI_MASTER_DATA_WIDTH = 32;

  // AR issue FSM
  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } ar_state_e;

  // Round-robin pick between two requesters. With both requesting, the port that did not win
  // last time goes next; otherwise the single requester wins. Returns the winning port index.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) begin
      return ~last_grant;
    end
    return req1;
  endfunction

endpackage

// File: rtl/sda_gmem_route_fifo.sv
// ---------------------------------------------------------------------------------------------
// sda_gmem_route_fifo
//   Synchronous 1-bit-wide FIFO recording which requester owns each outstanding read burst,
//   in grant order.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   push       in   write push_data (ignored when full)
//   push_data  in   owning port index
//   pop        in   drop the head entry (ignored when empty)
//   head       out  owning port of the oldest outstanding burst
//   empty      out  no entries
//   full       out  DEPTH entries
//   count      out  number of entries, 0..DEPTH
// ---------------------------------------------------------------------------------------------
module sda_gmem_route_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  push_data,
  input  logic                  pop,
  output logic                  head,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  logic [DEPTH-1:0]      r_mem;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // simultaneous push and pop leaves the count unchanged
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sda_gmem_read_arbiter.sv
// ---------------------------------------------------------------------------------------------
// sda_gmem_read_arbiter
//   Shares the gmem AXI4 master read channel (AR/R) between two internal read requesters.
//   AR requests are arbitrated round-robin and issued through a registered stage; the grant
//   order is recorded in a route FIFO and R beats are steered back to the owning requester in
//   order. No ID remapping is done.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   sN_araddr/arlen/arsize/arburst   requester N burst request fields
//   sN_arvalid / sN_arready          requester N AR handshake
//   sN_rdata/rresp/rlast             read data fanned to both requesters
//   sN_rvalid / sN_rready            requester N R handshake
//   m_araddr/arlen/arsize/arburst    registered AR towards gmem
//   m_arvalid / m_arready            gmem AR handshake
//   m_rdata/rresp/rlast              read data from gmem
//   m_rvalid / m_rready              gmem R handshake
// ---------------------------------------------------------------------------------------------
module sda_gmem_read_arbiter
  import sda_gmem_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = AXI_MASTER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = AXI_MASTER_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned OUTSTANDING_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // gmem master
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int unsigned COUNT_WIDTH = OUTSTANDING_LOG2 + 1;

  ar_state_e             r_state;
  ar_state_e             w_state_next;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_arvalid;

  logic                  w_winner;
  logic                  w_grant;
  logic                  w_head;
  logic                  w_empty;
  logic                  w_full;
  logic [COUNT_WIDTH-1:0] w_count;
  logic                  w_sel_rready;
  logic                  w_pop;

  // -------------------------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------------------------
  assign w_winner = rr_pick(s0_arvalid, s1_arvalid, r_last_grant);

  // A grant needs the FSM idle and room for another outstanding burst. Gating with reset keeps
  // both arready outputs low while the block is being reset.
  assign w_grant = (r_state == StIdle) & ~w_full & (s0_arvalid | s1_arvalid) & ~reset;

  // -------------------------------------------------------------------------------------------
  // AR FSM: state register
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // AR FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant)   w_state_next = StIssue;
      StIssue: if (m_arready) w_state_next = StIdle;
    endcase
  end

  // AR FSM: outputs. arready is a single-cycle combinational acknowledge of the winner.
  always_comb begin
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    if (w_grant) begin
      s0_arready = ~w_winner;
      s1_arready = w_winner;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Registered AR stage
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_arvalid    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_araddr     <= w_winner ? s1_araddr  : s0_araddr;
      r_arlen      <= w_winner ? s1_arlen   : s0_arlen;
      r_arsize     <= w_winner ? s1_arsize  : s0_arsize;
      r_arburst    <= w_winner ? s1_arburst : s0_arburst;
      r_arvalid    <= 1'b1;
      r_last_grant <= w_winner;
    end else if (r_arvalid && m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = r_arburst;
  assign m_arvalid = r_arvalid;

  // -------------------------------------------------------------------------------------------
  // Route FIFO: one entry per granted burst, popped on the last beat
  // -------------------------------------------------------------------------------------------
  sda_gmem_route_fifo #(
    .DEPTH      (MAX_OUTSTANDING),
    .DEPTH_LOG2 (OUTSTANDING_LOG2)
  ) u_route_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_grant),
    .push_data (w_winner),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  // -------------------------------------------------------------------------------------------
  // R steering. An empty FIFO keeps m_rready low so a stray beat from gmem is never routed.
  // -------------------------------------------------------------------------------------------
  assign w_sel_rready = w_head ? s1_rready : s0_rready;
  assign m_rready     = ~w_empty & w_sel_rready;
  assign s0_rvalid    = m_rvalid & ~w_empty & ~w_head;
  assign s1_rvalid    = m_rvalid & ~w_empty & w_head;
  assign w_pop        = m_rvalid & m_rready & m_rlast;

  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  // The route FIFO can never hold more bursts than the outstanding limit
  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    w_count <= COUNT_WIDTH'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
module tb_sda_gmem_read_arbiter;
  import sda_gmem_read_arbiter_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int LOG2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]    s0_arlen, s1_arlen, m_arlen;
  logic [2:0]    s0_arsize, s1_arsize, m_arsize;
  logic [1:0]    s0_arburst, s1_arburst, m_arburst;
  logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready, m_arvalid, m_arready;
  logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]    s0_rresp, s1_rresp, m_rresp;
  logic          s0_rlast, s1_rlast, m_rlast;
  logic          s0_rvalid, s1_rvalid, m_rvalid, s0_rready, s1_rready, m_rready;

  sda_gmem_read_arbiter #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .MAX_OUTSTANDING  (MAXO),
    .OUTSTANDING_LOG2 (LOG2)
  ) dut (
    .clk        (clk),        .reset      (reset),
    .s0_araddr  (s0_araddr),  .s0_arlen   (s0_arlen),   .s0_arsize  (s0_arsize),
    .s0_arburst (s0_arburst), .s0_arvalid (s0_arvalid), .s0_arready (s0_arready),
    .s0_rdata   (s0_rdata),   .s0_rresp   (s0_rresp),   .s0_rlast   (s0_rlast),
    .s0_rvalid  (s0_rvalid),  .s0_rready  (s0_rready),
    .s1_araddr  (s1_araddr),  .s1_arlen   (s1_arlen),   .s1_arsize  (s1_arsize),
    .s1_arburst (s1_arburst), .s1_arvalid (s1_arvalid), .s1_arready (s1_arready),
    .s1_rdata   (s1_rdata),   .s1_rresp   (s1_rresp),   .s1_rlast   (s1_rlast),
    .s1_rvalid  (s1_rvalid),  .s1_rready  (s1_rready),
    .m_araddr   (m_araddr),   .m_arlen    (m_arlen),    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),  .m_arvalid  (m_arvalid),  .m_arready  (m_arready),
    .m_rdata    (m_rdata),    .m_rresp    (m_rresp),    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),   .m_rready   (m_rready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  typedef struct {
    bit port;
    int len;
    int serial;
  } own_t;

  ar_t  req_q0[$];    // stimulus waiting to be offered by requester 0
  ar_t  req_q1[$];
  ar_t  exp_ar_q[$];  // scoreboard: ARs accepted from requesters, expected on the master port
  own_t own_q[$];     // reference model: owners of outstanding bursts in grant order

  int checks = 0;
  int errors = 0;

  // reference model state
  int mdl_count   = 0;
  bit mdl_pending = 1'b0;
  bit mdl_last    = 1'b1;
  int mdl_serial  = 0;
  int mdl_beat    = 0;

  // stimulus configuration
  int cfg_req_pct    = 100;
  int cfg_rvalid_pct = 100;
  int cfg_arready    = 0;   // 0: always ready, 1: random, 2: held low
  bit cfg_rready_rnd = 1'b0;
  bit cfg_spurious   = 1'b0;
  bit drv_busy[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ar_t mk_ar(input logic [AW-1:0] a, input int l, input int s, input int b);
    ar_t r;
    r.addr  = a;
    r.len   = 8'(l);
    r.size  = 3'(s);
    r.burst = 2'(b);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Requester drivers: offer queued requests, push accepted ones to the scoreboard
  // ---------------------------------------------------------------------------
  initial begin : requesters
    ar_t cur[2];
    bit  busy[2];
    bit  hs[2];
    bit  rst_seen;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; cur[p] = mk_ar('0, 0, 0, 0); drv_busy[p] = 1'b0;
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b1; s1_rready = 1'b1;
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
    forever begin
      @(negedge clk);
      rst_seen = reset;
      hs[0] = s0_arvalid && s0_arready;
      hs[1] = s1_arvalid && s1_arready;
      for (int p = 0; p < 2; p++) if (hs[p]) exp_ar_q.push_back(cur[p]);
      @(posedge clk); #1;
      if (rst_seen) begin req_q0.delete(); req_q1.delete(); end
      for (int p = 0; p < 2; p++) begin
        if (hs[p] || rst_seen) busy[p] = 1'b0;
        if (!busy[p] && !rst_seen && $urandom_range(0, 99) < cfg_req_pct) begin
          if (p == 0 && req_q0.size() > 0) begin cur[p] = req_q0.pop_front(); busy[p] = 1'b1; end
          if (p == 1 && req_q1.size() > 0) begin cur[p] = req_q1.pop_front(); busy[p] = 1'b1; end
        end
        drv_busy[p] = busy[p];
      end
      s0_arvalid = busy[0]; s0_araddr = cur[0].addr; s0_arlen = cur[0].len;
      s0_arsize = cur[0].size; s0_arburst = cur[0].burst;
      s1_arvalid = busy[1]; s1_araddr = cur[1].addr; s1_arlen = cur[1].len;
      s1_arsize = cur[1].size; s1_arburst = cur[1].burst;
      s0_rready = cfg_rready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s1_rready = cfg_rready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // gmem slave model: accepts ARs, returns bursts whose data encodes burst/beat
  // ---------------------------------------------------------------------------
  initial begin : slave
    int lens[$];
    int beat = 0;
    int done = 0;
    bit holding = 1'b0;
    bit rst_seen, ar_hs, r_hs;
    logic [7:0] alen;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      rst_seen = reset;
      ar_hs = m_arvalid && m_arready;
      alen = m_arlen;
      r_hs = m_rvalid && m_rready;
      @(posedge clk); #1;
      if (rst_seen) begin
        lens.delete(); beat = 0; done = 0; holding = 1'b0;
      end else begin
        if (ar_hs) lens.push_back(int'(alen));
        if (r_hs && holding) begin
          holding = 1'b0;
          if (beat == lens[0]) begin
            void'(lens.pop_front()); beat = 0; done++;
          end else begin
            beat++;
          end
        end
      end
      if (!holding) begin
        if (lens.size() > 0 && $urandom_range(0, 99) < cfg_rvalid_pct) begin
          holding = 1'b1;
          m_rvalid = 1'b1;
          m_rdata  = {done[23:0], 8'hA0 + beat[7:0]};
          m_rresp  = ($urandom_range(0, 3) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          m_rlast  = (beat == lens[0]);
        end else if (cfg_spurious && lens.size() == 0 && mdl_count == 0 &&
                     $urandom_range(0, 4) == 0) begin
          // protocol violation: data with nothing outstanding
          m_rvalid = 1'b1; m_rdata = $urandom; m_rresp = AXI_RESP_OKAY; m_rlast = 1'b1;
        end else begin
          m_rvalid = 1'b0; m_rdata = $urandom; m_rlast = 1'($urandom_range(0, 1));
        end
      end
      case (cfg_arready)
        0:       m_arready = 1'b1;
        1:       m_arready = 1'($urandom_range(0, 1));
        default: m_arready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor + reference model, sampled on the falling edge
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit v0, v1, exp_grant, exp_win, ar_hs, p, exp_last;
    logic [31:0] exp_data;
    logic [7:0]  win_len;
    int ser;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("s0_arready_in_reset", s0_arready, 1'b0);
        chk("s1_arready_in_reset", s1_arready, 1'b0);
        mdl_count = 0; mdl_pending = 1'b0; mdl_last = 1'b1; mdl_serial = 0; mdl_beat = 0;
        own_q.delete(); exp_ar_q.delete();
        continue;
      end
      v0 = s0_arvalid; v1 = s1_arvalid;
      exp_grant = !mdl_pending && (mdl_count < MAXO) && (v0 || v1);
      exp_win   = (v0 && v1) ? !mdl_last : v1;
      chk("s0_arready", s0_arready, exp_grant && !exp_win);
      chk("s1_arready", s1_arready, exp_grant && exp_win);
      chk("m_arvalid", m_arvalid, mdl_pending);
      if (m_arvalid) begin
        if (exp_ar_q.size() == 0) begin
          chk("m_ar_expected", 1'b0, 1'b1);
        end else begin
          chk("m_araddr", m_araddr, exp_ar_q[0].addr);
          chk("m_arlen", m_arlen, exp_ar_q[0].len);
          chk("m_arsize", m_arsize, exp_ar_q[0].size);
          chk("m_arburst", m_arburst, exp_ar_q[0].burst);
        end
      end
      ar_hs = m_arvalid && m_arready && mdl_pending;

      if (own_q.size() == 0) begin
        chk("m_rready_empty", m_rready, 1'b0);
        chk("s0_rvalid_empty", s0_rvalid, 1'b0);
        chk("s1_rvalid_empty", s1_rvalid, 1'b0);
      end else begin
        p = own_q[0].port;
        chk("sel_rvalid", p ? s1_rvalid : s0_rvalid, m_rvalid);
        chk("other_rvalid", p ? s0_rvalid : s1_rvalid, 1'b0);
        chk("m_rready", m_rready, p ? s1_rready : s0_rready);
        if (m_rvalid) begin
          ser      = own_q[0].serial;
          exp_data = {ser[23:0], 8'hA0 + mdl_beat[7:0]};
          exp_last = (mdl_beat == own_q[0].len);
          chk("sel_rdata", p ? s1_rdata : s0_rdata, exp_data);
          chk("sel_rresp", p ? s1_rresp : s0_rresp, m_rresp);
          chk("sel_rlast", p ? s1_rlast : s0_rlast, exp_last);
          chk("other_rdata", p ? s0_rdata : s1_rdata, m_rdata);
          if (m_rready) begin
            if (exp_last) begin
              void'(own_q.pop_front()); mdl_count--; mdl_beat = 0;
            end else begin
              mdl_beat++;
            end
          end
        end
      end

      if (ar_hs) begin
        void'(exp_ar_q.pop_front()); mdl_pending = 1'b0;
      end
      if (exp_grant) begin
        win_len = exp_win ? s1_arlen : s0_arlen;
        own_q.push_back('{port: exp_win, len: int'(win_len), serial: mdl_serial});
        mdl_serial++; mdl_count++; mdl_pending = 1'b1; mdl_last = exp_win;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((req_q0.size() > 0 || req_q1.size() > 0 || drv_busy[0] || drv_busy[1] ||
            own_q.size() > 0 || mdl_pending) && n < bound) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles with %0d bursts outstanding, required 0",
               name, n, own_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: single requester, len 3
    req_q0.push_back(mk_ar(64'h1000, 3, 2, AXI_BURST_INCR));
    wait_idle("t1_single", 100);

    // 2: both from reset, s0 first
    do_reset();
    req_q0.push_back(mk_ar(64'h2000, 1, 2, AXI_BURST_INCR));
    req_q1.push_back(mk_ar(64'h3000, 1, 2, AXI_BURST_INCR));
    wait_idle("t2_both", 100);

    // 3: continuous contention, strict alternation
    for (int i = 0; i < 4; i++) begin
      req_q0.push_back(mk_ar(64'h4000 + 64'(i * 'h100), i, 2, AXI_BURST_INCR));
      req_q1.push_back(mk_ar(64'h5000 + 64'(i * 'h100), 3 - i, 2, AXI_BURST_INCR));
    end
    wait_idle("t3_alternate", 200);

    // 4: outstanding limit with no read data returning
    cfg_rvalid_pct = 0;
    for (int i = 0; i < 6; i++) req_q0.push_back(mk_ar(64'h6000 + 64'(i * 'h40), 1, 2, 1));
    repeat (30) @(posedge clk);
    #1 cfg_rvalid_pct = 100;
    wait_idle("t4_full", 200);

    // 5: m_arready held low after issue
    cfg_arready = 2;
    req_q0.push_back(mk_ar(64'h7000, 2, 2, AXI_BURST_INCR));
    req_q1.push_back(mk_ar(64'h7800, 0, 2, AXI_BURST_INCR));
    repeat (12) @(posedge clk);
    #1 cfg_arready = 0;
    wait_idle("t5_stall", 100);

    // 6: reset during the second beat of a len 3 burst
    req_q1.push_back(mk_ar(64'h8000, 0, 2, AXI_BURST_INCR));
    wait_idle("t6_prep", 50);
    req_q0.push_back(mk_ar(64'h9000, 3, 2, AXI_BURST_INCR));
    n = 0;
    while (mdl_beat != 1 && n < 50) begin @(posedge clk); n++; end
    chk("t6_reached_beat2", 64'(mdl_beat), 64'd1);
    do_reset();
    req_q0.push_back(mk_ar(64'hA000, 0, 2, AXI_BURST_INCR));
    req_q1.push_back(mk_ar(64'hB000, 0, 2, AXI_BURST_INCR));
    wait_idle("t6_after_reset", 100);

    // 7: randomized traffic
    cfg_req_pct = 60; cfg_rvalid_pct = 70; cfg_arready = 1;
    cfg_rready_rnd = 1'b1; cfg_spurious = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1)
        req_q1.push_back(mk_ar({$urandom, $urandom}, $urandom_range(0, 7), 2,
                               $urandom_range(0, 2)));
      else
        req_q0.push_back(mk_ar({$urandom, $urandom}, $urandom_range(0, 7), 2,
                               $urandom_range(0, 2)));
    end
    wait_idle("t7_random", 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
